mc_decoder: RTL and testbench
=============================

# mc_decoder

Multicycle control unit for the ARM datapath: a state machine that sequences fetch, decode, address, memory and write-back steps over several cycles instead of one. It drives the shared-memory multicycle datapath's mux selects and write enables, and decodes the ALU operation for data-processing (DP) instructions, adding EOR and the compare/test family. It waits on a memory ready handshake so that variable-latency memory can stall it. The conditional-execution unit sits downstream and gates PCWrite, RegW, MemW and FlagW by the condition check.

## Interface
- ALUCTRL_W, 3: width of ALUControl; must be ≥3; encodings are zero-extended.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Reset assertion takes effect immediately; reset release is synchronous to clk.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S (L for memory instructions).
- Rd  in  4  destination register.
- mem_ready  in  1  memory has completed the current access this cycle.
- IRWrite, NextPC, PCWrite, RegW, MemW, NoWrite  out  1 each.
- AdrSrc, ALUSrcA  out  1 each.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW  out  2 each.
- ALUControl  out  ALUCTRL_W.
- state  out  4  current state, for debug and verification.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Transitions:
  - FETCH→DECODE only when mem_ready=1; otherwise it holds in FETCH.
  - DECODE, by Op:
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=00 with Funct[5]=0 → EXECR.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=11 → FETCH (unimplemented; no write enables asserted).
  - MEMADR→MEMRD if Funct[0]=1, otherwise MEMADR→MEMWR.
  - MEMRD→MEMWB when mem_ready=1; otherwise it holds.
  - MEMWR→FETCH when mem_ready=1; otherwise it holds.
  - EXECR and EXECI→ALUWB.
  - MEMWB, ALUWB and BRANCH→FETCH.
  - Unused encodings 10..15 →FETCH.
- Per-state outputs; all unlisted outputs are 0:
  - FETCH: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=mem_ready.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1; held asserted until mem_ready.
  - EXECR: ALUSrcB=00 with DP decode active.
  - EXECI: ALUSrcB=01 with DP decode active.
  - ALUWB: RegW=~NoWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10.
- PCWrite = NextPC | (state==BRANCH) | (RegW & Rd==4'hF).
- ImmSrc and RegSrc are combinational from Op in every state:
  - Op=00: ImmSrc=00, RegSrc=00.
  - Op=01: ImmSrc=01, RegSrc=10.
  - Op=10: ImmSrc=10, RegSrc=01.
- DP decode on Funct[4:1] (active in EXECR, EXECI and ALUWB; elsewhere ALUControl=ADD and FlagW=00):
  - 0100 → ADD=000.
  - 0010 → SUB=001.
  - 0000 → AND=010.
  - 1100 → ORR=011.
  - 0001 → EOR=100.
  - Any other code → ALUControl=ADD, NoWrite=1, FlagW=00.
- NoWrite is held from EXECx through ALUWB.
- Flag writes: FlagW[1]=Funct[0], asserted only in EXECR/EXECI. FlagW[0]=Funct[0] & (ADD|SUB|CMP|CMN).

## Timing
- Cycle counts assume memory with zero wait states (mem_ready=1 in the first cycle of each access):
  - DP instruction: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
- Each memory-wait cycle adds 1 cycle in FETCH, MEMRD or MEMWR.
- All outputs are combinational from state, Op, Funct, Rd and mem_ready. The only registers are state and the NoWrite latch.
- During reset:
  - state=FETCH and NoWrite=0.
  - IRWrite, NextPC, PCWrite, RegW, MemW and FlagW are forced to 0.
  - Select outputs take their FETCH values: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0, ALUControl=0.
- Reset asserted mid-instruction aborts it immediately. No write enable glitches high.

## Configuration
- DECODER_CMP_EN defined: the DP decode also accepts the compare/test family, each with NoWrite=1:
  - 1010 CMP → SUB.
  - 1011 CMN → ADD.
  - 1000 TST → AND.
  - If S=0, these codes are treated as unimplemented.
- DECODER_CMP_EN undefined: these codes fall into the unimplemented path (ADD, NoWrite=1, FlagW=00).

## Test plan
- ADD, register operand (Op=00, Funct=001000, Rd=3), mem_ready=1:
  - States 0→1→6→8→0.
  - RegW=1 only in ALUWB; ALUControl=000; FlagW=00.
- LDR (Op=01, Funct=011001) with mem_ready low for 2 cycles in MEMRD:
  - States 0→1→2→3→3→3→4→0.
  - AdrSrc=1 during MEMRD; RegW=1 in MEMWB.
- STR with mem_ready low for 3 cycles in FETCH:
  - IRWrite=0 for 3 cycles, then 1 for one cycle.
  - MemW held at 1 throughout MEMWR until mem_ready.
- SUBS to Rd=15 (Funct=000101):
  - FlagW=11 in EXECR.
  - PCWrite=1 in ALUWB.
- With DECODER_CMP_EN, CMP (Funct=010101): ALUControl=001, FlagW=11, RegW=0 in ALUWB. Without the macro: FlagW=00, RegW=0.
- Reset driven low while in MEMWR with MemW=1:
  - MemW drops to 0 within the same cycle and state reads 0.
  - After reset release, the next fetch proceeds normally.

Source files
------------

// File: rtl/mc_decoder_if.sv
// -----------------------------------------------------------------------------
// mc_decoder_if
//
// Bundle between the multicycle control unit and the shared-memory ARM
// datapath. The names match the datapath's control names so the wiring reads
// like the schematic.
//
//   Instruction fields and memory handshake (datapath -> control):
//     Op[1:0]      instruction bits [27:26]
//     Funct[5:0]   instruction bits [25:20] (I, cmd[3:0], S/L)
//     Rd[3:0]      destination register
//     mem_ready    memory completed the current access this cycle
//   Control (control -> datapath / conditional-execution unit):
//     IRWrite, NextPC, PCWrite, RegW, MemW, NoWrite, AdrSrc, ALUSrcA
//     ALUSrcB[1:0], ResultSrc[1:0], ImmSrc[1:0], RegSrc[1:0], FlagW[1:0]
//     ALUControl[ALUCTRL_W-1:0]
//
// Modports:
//   master  the control unit (drives the control signals)
//   slave   the datapath (drives the instruction fields and mem_ready)
// -----------------------------------------------------------------------------
interface mc_decoder_if #(
  parameter int ALUCTRL_W = 3
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 mem_ready;

  logic                 IRWrite;
  logic                 NextPC;
  logic                 PCWrite;
  logic                 RegW;
  logic                 MemW;
  logic                 NoWrite;
  logic                 AdrSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [1:0]           FlagW;
  logic [ALUCTRL_W-1:0] ALUControl;

  modport master (
    input  Op, Funct, Rd, mem_ready,
    output IRWrite, NextPC, PCWrite, RegW, MemW, NoWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl
  );

  modport slave (
    output Op, Funct, Rd, mem_ready,
    input  IRWrite, NextPC, PCWrite, RegW, MemW, NoWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl
  );
endinterface

// File: rtl/mc_decoder.sv
// -----------------------------------------------------------------------------
// mc_decoder
//
// Multicycle control unit for the shared-memory ARM datapath. Sequences each
// instruction through fetch, decode, address, memory and write-back steps,
// stalling in FETCH, MEMRD and MEMWR until mem_ready. Decodes the ALU
// operation for data-processing instructions (ADD, SUB, AND, ORR, EOR and,
// optionally, CMP/CMN/TST). PCWrite, RegW, MemW and FlagW are further gated
// downstream by the conditional-execution unit.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous assert, active-low; release is expected to be
//           synchronous to clk
//   bus     mc_decoder_if.master (instruction fields, mem_ready, controls)
//   state   current FSM state, for debug and verification
//
// Parameters:
//   ALUCTRL_W  width of ALUControl (>= 3); encodings are zero-extended
//
// Configuration macro:
//   DECODER_CMP_EN  when defined, the DP decoder also accepts CMP (SUB),
//                   CMN (ADD) and TST (AND) with S=1, all with NoWrite=1.
//                   When undefined those codes take the unimplemented path.
//
// All outputs are combinational from state, Op, Funct, Rd and mem_ready; the
// only registers are the state and the NoWrite hold bit.
// -----------------------------------------------------------------------------
module mc_decoder #(
  parameter int ALUCTRL_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  mc_decoder_if.master bus,
  output logic [3:0]   state
);

  if (ALUCTRL_W < 3) begin : g_width_check
    $error("mc_decoder: ALUCTRL_W must be at least 3");
  end

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_EOR = 3'b100
  } alu_op_t;

  // Select encodings shared by several states.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU   = 2'b10;

  state_t  state_q;
  state_t  state_d;
  logic    nowrite_q;
  logic    nowrite_d;

  // ---------------------------------------------------------------------------
  // Data-processing decode (only consumed in EXECR, EXECI and ALUWB)
  // ---------------------------------------------------------------------------
  alu_op_t    dp_alu;
  logic       dp_valid;    // cmd is an implemented DP operation
  logic       dp_nowrite;  // result must not reach the register file
  logic       dp_arith;    // operation produces meaningful C/V flags
  logic [1:0] dp_flagw;

  // NOTE: every signal driven from always_comb gets a default at the top so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dp_alu     = ALU_ADD;
    dp_valid   = 1'b1;
    dp_nowrite = 1'b0;
    dp_arith   = 1'b0;

    case (bus.Funct[4:1])
      4'b0100: begin
        dp_alu   = ALU_ADD;
        dp_arith = 1'b1;
      end
      4'b0010: begin
        dp_alu   = ALU_SUB;
        dp_arith = 1'b1;
      end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0001: dp_alu = ALU_EOR;
`ifdef DECODER_CMP_EN
      // Compare/test only make sense with S=1; without it they would have no
      // architectural effect, so they are rejected as unimplemented.
      4'b1010: begin
        if (bus.Funct[0]) begin
          dp_alu     = ALU_SUB;
          dp_nowrite = 1'b1;
          dp_arith   = 1'b1;
        end else begin
          dp_valid = 1'b0;
        end
      end
      4'b1011: begin
        if (bus.Funct[0]) begin
          dp_alu     = ALU_ADD;
          dp_nowrite = 1'b1;
          dp_arith   = 1'b1;
        end else begin
          dp_valid = 1'b0;
        end
      end
      4'b1000: begin
        if (bus.Funct[0]) begin
          dp_alu     = ALU_AND;
          dp_nowrite = 1'b1;
        end else begin
          dp_valid = 1'b0;
        end
      end
`endif
      default: dp_valid = 1'b0;
    endcase

    // Unimplemented codes still flow through EXECx/ALUWB but change nothing.
    if (!dp_valid) begin
      dp_alu     = ALU_ADD;
      dp_nowrite = 1'b1;
      dp_arith   = 1'b0;
    end
  end

  // FlagW[1] covers N/Z, FlagW[0] covers C/V (only arithmetic ops set them).
  assign dp_flagw = dp_valid ? {bus.Funct[0], bus.Funct[0] & dp_arith} : 2'b00;

  // ---------------------------------------------------------------------------
  // State register and NoWrite hold bit
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nowrite_q <= nowrite_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;  // Op=11 returns to fetch with no writes
        endcase
      end
      MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWR:  if (bus.mem_ready) state_d = FETCH;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      // MEMWB, ALUWB, BRANCH and the unused encodings all return to FETCH.
      default: state_d = FETCH;
    endcase
  end

  // The NoWrite decision is captured while executing and kept through the
  // write-back step, then cleared so it never leaks into the next instruction.
  always_comb begin
    case (state_q)
      EXECR, EXECI: nowrite_d = dp_nowrite;
      ALUWB:        nowrite_d = nowrite_q;
      default:      nowrite_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic       irwrite;
  logic       nextpc;
  logic       pcwrite;
  logic       regw;
  logic       memw;
  logic       nowrite_o;
  logic       adrsrc;
  logic       alusrca;
  logic       is_branch;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [1:0] immsrc;
  logic [1:0] regsrc;
  logic [1:0] flagw;
  alu_op_t    alu_sel;

  always_comb begin
    irwrite   = 1'b0;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    nowrite_o = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    is_branch = 1'b0;
    alusrcb   = SRCB_REG;
    resultsrc = 2'b00;
    flagw     = 2'b00;
    alu_sel   = ALU_ADD;

    case (state_q)
      FETCH: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        // Latch the instruction and bump the PC only once memory delivers.
        irwrite   = bus.mem_ready;
        nextpc    = bus.mem_ready;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
      end
      MEMADR: alusrcb = SRCB_IMM;
      MEMRD:  adrsrc  = 1'b1;
      MEMWB: begin
        resultsrc = RES_DATA;
        regw      = 1'b1;
      end
      MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      EXECR: begin
        alusrcb   = SRCB_REG;
        alu_sel   = dp_alu;
        flagw     = dp_flagw;
        nowrite_o = dp_nowrite;
      end
      EXECI: begin
        alusrcb   = SRCB_IMM;
        alu_sel   = dp_alu;
        flagw     = dp_flagw;
        nowrite_o = dp_nowrite;
      end
      ALUWB: begin
        alu_sel   = dp_alu;
        nowrite_o = nowrite_q;
        regw      = ~nowrite_q;
      end
      BRANCH: begin
        alusrcb   = SRCB_IMM;
        resultsrc = RES_ALU;
        is_branch = 1'b1;
      end
      default: ;
    endcase

    // The state register already sits in FETCH while reset is low, so the
    // selects show their FETCH values; the enables are additionally forced
    // low so a high mem_ready during reset cannot pulse IRWrite/NextPC.
    if (!reset) begin
      irwrite = 1'b0;
      nextpc  = 1'b0;
      regw    = 1'b0;
      memw    = 1'b0;
      flagw   = 2'b00;
    end
  end

  // A write-back to R15 is a jump, so it must also update the PC.
  assign pcwrite = nextpc | is_branch | (regw & (bus.Rd == 4'hF));

  // Immediate extension and register-port selection depend only on the class.
  always_comb begin
    case (bus.Op)
      2'b01: begin
        immsrc = 2'b01;
        regsrc = 2'b10;
      end
      2'b10: begin
        immsrc = 2'b10;
        regsrc = 2'b01;
      end
      default: begin
        immsrc = 2'b00;
        regsrc = 2'b00;
      end
    endcase
  end

  assign bus.IRWrite    = irwrite;
  assign bus.NextPC     = nextpc;
  assign bus.PCWrite    = pcwrite;
  assign bus.RegW       = regw;
  assign bus.MemW       = memw;
  assign bus.NoWrite    = nowrite_o;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ImmSrc     = immsrc;
  assign bus.RegSrc     = regsrc;
  assign bus.FlagW      = flagw;
  assign bus.ALUControl = ALUCTRL_W'(alu_sel);
  assign state          = state_q;

endmodule

// File: tb/tb_mc_decoder.sv
// -----------------------------------------------------------------------------
// tb_mc_decoder
//
// Self-checking bench for mc_decoder. Each instruction is expanded into its
// expected per-cycle walk (state plus all control outputs) from the
// instruction class and the memory wait counts; the driver applies the
// inputs for each cycle and pushes the expected vector, and an independent
// monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_mc_decoder;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_MEMADR = 2;
  localparam int S_MEMRD  = 3;
  localparam int S_MEMWB  = 4;
  localparam int S_MEMWR  = 5;
  localparam int S_EXECR  = 6;
  localparam int S_EXECI  = 7;
  localparam int S_ALUWB  = 8;
  localparam int S_BRANCH = 9;

  typedef struct packed {
    logic [3:0] state;
    logic       irwrite;
    logic       nextpc;
    logic       pcwrite;
    logic       regw;
    logic       memw;
    logic       nowrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] flagw;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    ctrl_t mask;
    string tag;
  } sb_t;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  sb_t   sb[$];
  step_t plan[$];

  mc_decoder_if #(.ALUCTRL_W(3)) bus ();

  mc_decoder #(.ALUCTRL_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference DP decode: the table of implemented commands.
  function automatic void dp_ref(input logic [5:0] f, output logic [2:0] alu,
                                 output logic nw, output logic [1:0] fw);
    logic s;
    logic ok;
    logic arith;
    s     = f[0];
    ok    = 1'b1;
    arith = 1'b0;
    nw    = 1'b0;
    alu   = 3'b000;
    case (f[4:1])
      4'b0100: begin alu = 3'b000; arith = 1'b1; end
      4'b0010: begin alu = 3'b001; arith = 1'b1; end
      4'b0000: alu = 3'b010;
      4'b1100: alu = 3'b011;
      4'b0001: alu = 3'b100;
`ifdef DECODER_CMP_EN
      4'b1010: begin alu = 3'b001; arith = 1'b1; nw = 1'b1; ok = s; end
      4'b1011: begin alu = 3'b000; arith = 1'b1; nw = 1'b1; ok = s; end
      4'b1000: begin alu = 3'b010; nw = 1'b1; ok = s; end
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      alu = 3'b000;
      nw  = 1'b1;
      fw  = 2'b00;
    end else begin
      fw = {s, s & arith};
    end
  endfunction

  // Expected control vector for one cycle in state st.
  function automatic ctrl_t model(input int st, input logic [1:0] op,
                                  input logic [5:0] f, input logic [3:0] rd,
                                  input logic mr);
    ctrl_t      c;
    logic [2:0] alu;
    logic       nw;
    logic [1:0] fw;
    c = '0;
    c.state = 4'(st);
    dp_ref(f, alu, nw, fw);
    if (op == 2'b01) begin c.immsrc = 2'b01; c.regsrc = 2'b10; end
    if (op == 2'b10) begin c.immsrc = 2'b10; c.regsrc = 2'b01; end
    case (st)
      S_FETCH: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
        c.irwrite = mr;   c.nextpc = mr;
      end
      S_DECODE: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      S_MEMADR: c.alusrcb = 2'b01;
      S_MEMRD:  c.adrsrc = 1'b1;
      S_MEMWB:  begin c.resultsrc = 2'b01; c.regw = 1'b1; end
      S_MEMWR:  begin c.adrsrc = 1'b1; c.memw = 1'b1; end
      S_EXECR:  begin c.alucontrol = alu; c.flagw = fw; c.nowrite = nw; end
      S_EXECI:  begin
        c.alusrcb = 2'b01; c.alucontrol = alu; c.flagw = fw; c.nowrite = nw;
      end
      S_ALUWB:  begin c.alucontrol = alu; c.nowrite = nw; c.regw = ~nw; end
      S_BRANCH: begin c.alusrcb = 2'b01; c.resultsrc = 2'b10; end
      default: ;
    endcase
    c.pcwrite = c.nextpc | (st == S_BRANCH) | (c.regw & (rd == 4'hF));
    return c;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t c;
    c.state      = state;
    c.irwrite    = bus.IRWrite;
    c.nextpc     = bus.NextPC;
    c.pcwrite    = bus.PCWrite;
    c.regw       = bus.RegW;
    c.memw       = bus.MemW;
    c.nowrite    = bus.NoWrite;
    c.adrsrc     = bus.AdrSrc;
    c.alusrca    = bus.ALUSrcA;
    c.alusrcb    = bus.ALUSrcB;
    c.resultsrc  = bus.ResultSrc;
    c.immsrc     = bus.ImmSrc;
    c.regsrc     = bus.RegSrc;
    c.flagw      = bus.FlagW;
    c.alucontrol = bus.ALUControl;
    return c;
  endfunction

  task automatic add_step(input int st, input logic mr);
    step_t s;
    s.st = st;
    s.mr = mr;
    plan.push_back(s);
  endtask

  // Instruction-level walk: fetch waits, decode, class-specific steps.
  task automatic build_plan(input logic [1:0] op, input logic [5:0] f,
                            input int wf, input int wm);
    plan.delete();
    repeat (wf) add_step(S_FETCH, 1'b0);
    add_step(S_FETCH, 1'b1);
    add_step(S_DECODE, 1'($urandom_range(0, 1)));
    case (op)
      2'b00: begin
        add_step(f[5] ? S_EXECI : S_EXECR, 1'($urandom_range(0, 1)));
        add_step(S_ALUWB, 1'($urandom_range(0, 1)));
      end
      2'b01: begin
        add_step(S_MEMADR, 1'($urandom_range(0, 1)));
        if (f[0]) begin
          repeat (wm) add_step(S_MEMRD, 1'b0);
          add_step(S_MEMRD, 1'b1);
          add_step(S_MEMWB, 1'($urandom_range(0, 1)));
        end else begin
          repeat (wm) add_step(S_MEMWR, 1'b0);
          add_step(S_MEMWR, 1'b1);
        end
      end
      2'b10: add_step(S_BRANCH, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  task automatic drive_plan(input logic [1:0] op, input logic [5:0] f,
                            input logic [3:0] rd, input string tag);
    sb_t e;
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      bus.Op        = op;
      bus.Funct     = f;
      bus.Rd        = rd;
      bus.mem_ready = plan[i].mr;
      e.exp  = model(plan[i].st, op, f, rd, plan[i].mr);
      e.mask = '1;
      // Op=11 has no defined ImmSrc/RegSrc.
      if (op == 2'b11) begin
        e.mask.immsrc = 2'b00;
        e.mask.regsrc = 2'b00;
      end
      e.tag = $sformatf("%s c%0d st%0d", tag, i, plan[i].st);
      sb.push_back(e);
      mon_en = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int wf, input int wm,
                           input string tag);
    build_plan(op, f, wf, wm);
    drive_plan(op, f, rd, tag);
  endtask

  // Reset forces enables low and selects to their FETCH values.
  task automatic check_reset(input string tag);
    ctrl_t e;
    e = '0;
    e.alusrca   = 1'b1;
    e.alusrcb   = 2'b10;
    e.resultsrc = 2'b10;
    if (bus.Op == 2'b01) begin e.immsrc = 2'b01; e.regsrc = 2'b10; end
    if (bus.Op == 2'b10) begin e.immsrc = 2'b10; e.regsrc = 2'b01; end
    check({tag, "_state"}, 32'(state), 32'(S_FETCH));
    check({tag, "_memw"}, 32'(bus.MemW), 32'd0);
    check({tag, "_irwrite"}, 32'(bus.IRWrite), 32'd0);
    check({tag, "_vector"}, 32'(sample()), 32'(e));
  endtask

  ctrl_t mon_act;
  sb_t   mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got=empty expected=entry");
      end else begin
        mon_e   = sb.pop_front();
        mon_act = sample();
        check(mon_e.tag, 32'(mon_act & mon_e.mask),
              32'(mon_e.exp & mon_e.mask));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] rd;
    int         r;
    int         wf;
    int         wm;
    logic [3:0] cmds [8];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001,
             4'b1010, 4'b1011, 4'b1000};

    reset         = 1'b0;
    bus.Op        = 2'b00;
    bus.Funct     = 6'd0;
    bus.Rd        = 4'd0;
    bus.mem_ready = 1'b1;  // must not leak through as IRWrite during reset
    #12;
    check_reset("reset_init");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    run_instr(2'b00, 6'b001000, 4'd3,  0, 0, "add_r3");
    run_instr(2'b01, 6'b011001, 4'd2,  0, 2, "ldr_wait2");
    run_instr(2'b01, 6'b011000, 4'd5,  3, 2, "str_fwait3");
    run_instr(2'b00, 6'b000101, 4'hF,  0, 0, "subs_pc");
    run_instr(2'b00, 6'b010101, 4'd0,  0, 0, "cmp");
    run_instr(2'b00, 6'b010100, 4'd0,  0, 0, "cmp_nos");
    run_instr(2'b00, 6'b100011, 4'd7,  1, 0, "eors_imm");
    run_instr(2'b00, 6'b011111, 4'd1,  0, 0, "unimpl");
    run_instr(2'b10, 6'b000000, 4'd0,  0, 0, "branch");
    run_instr(2'b11, 6'b101010, 4'hF,  0, 0, "op11");
    run_instr(2'b01, 6'b011001, 4'hF,  0, 0, "ldr_pc");

    // Reset while a store is stalled in MEMWR with MemW high.
    plan.delete();
    add_step(S_FETCH, 1'b1);
    add_step(S_DECODE, 1'b0);
    add_step(S_MEMADR, 1'b0);
    add_step(S_MEMWR, 1'b0);
    drive_plan(2'b01, 6'b011000, 4'd4, "str_abort");
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("pre_abort_memw", 32'(bus.MemW), 32'd1);
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check_reset("reset_abort");
    @(posedge clk);
    #1;
    check_reset("reset_hold");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_instr(2'b00, 6'b101001, 4'd6, 0, 0, "after_reset");

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      f  = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 9) < 7)
        f[4:1] = cmds[$urandom_range(0, 7)];
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      wf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(op, f, rd, wf, wm, $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
